// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer
//   Runs a stored set of AES known-answer vectors through an external AES core.
//   Each vector is launched, the sequencer waits for the core result or a timeout,
//   and the result is compared with the expected ciphertext. A run ends with a done
//   pulse, a failure count, the index of the first failure, and a sticky pass flag.
//
// Ports
//   AES_clk, AES_rst_n        clock, asynchronous active-low reset
//   vec_wr_en/idx/pt/key/ct   write port into the vector store (only while idle)
//   start                     request a run over all NUM_VEC vectors
//   core_en                   enable to the AES core
//   core_data_in, core_key_in operands to the AES core
//   core_data_out(_valid)     result from the AES core
//   busy, done, pass          run status
//   fail_cnt, first_fail_idx  results of the last run
module aes_kat_sequencer #(
  parameter int NUM_VEC     = 4,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 64,
  parameter int EN_HOLD     = 1,
  localparam int IW         = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              vec_wr_en,
  input  logic [IW-1:0]     vec_wr_idx,
  input  logic [DATA_W-1:0] vec_wr_pt,
  input  logic [DATA_W-1:0] vec_wr_key,
  input  logic [DATA_W-1:0] vec_wr_ct,
  input  logic              start,
  output logic              core_en,
  output logic [DATA_W-1:0] core_data_in,
  output logic [DATA_W-1:0] core_key_in,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_data_out_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IW:0]       fail_cnt,
  output logic [IW-1:0]     first_fail_idx
);

  // Store is sized to the full index range so any idx value addresses a real entry;
  // entries at or above NUM_VEC are never written and never read.
  localparam int DEPTH = 1 << IW;
  localparam int TW    = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    FIN    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                core_en_q, core_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                tmo_q, tmo_d;
  logic [IW:0]         fail_cnt_q, fail_cnt_d;
  logic [IW-1:0]       ffi_q, ffi_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   res_q, res_d;

  logic [DATA_W-1:0]   pt_mem_q  [DEPTH];
  logic [DATA_W-1:0]   key_mem_q [DEPTH];
  logic [DATA_W-1:0]   ct_mem_q  [DEPTH];

  logic                wr_ok;
  assign wr_ok = vec_wr_en && !busy_q &&
                 ({1'b0, vec_wr_idx} < (IW+1)'(NUM_VEC));

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pt_mem_q[i]  <= '0;
        key_mem_q[i] <= '0;
        ct_mem_q[i]  <= '0;
      end
    end else if (wr_ok) begin
      pt_mem_q[vec_wr_idx]  <= vec_wr_pt;
      key_mem_q[vec_wr_idx] <= vec_wr_key;
      ct_mem_q[vec_wr_idx]  <= vec_wr_ct;
    end
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      fail_cnt_q <= '0;
      ffi_q      <= '0;
      din_q      <= '0;
      key_q      <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      core_en_q  <= core_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      fail_cnt_q <= fail_cnt_d;
      ffi_q      <= ffi_d;
      din_q      <= din_d;
      key_q      <= key_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    core_en_d  = core_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    fail_cnt_d = fail_cnt_q;
    ffi_d      = ffi_q;
    din_d      = din_q;
    key_d      = key_q;
    res_d      = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LAUNCH;
          idx_d      = '0;
          fail_cnt_d = '0;
          ffi_d      = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      LAUNCH: begin
        din_d     = pt_mem_q[idx_q];
        key_d     = key_mem_q[idx_q];
        core_en_d = 1'b1;
        timer_d   = '0;
        tmo_d     = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (EN_HOLD == 0) core_en_d = 1'b0;
        // A result arriving on the timeout cycle still counts as a result.
        if (core_data_out_valid) begin
          res_d     = core_data_out;
          core_en_d = 1'b0;
          state_d   = CHECK;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          tmo_d     = 1'b1;
          core_en_d = 1'b0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (tmo_q || (res_q != ct_mem_q[idx_q])) begin
          if (fail_cnt_q != (IW+1)'(NUM_VEC)) fail_cnt_d = fail_cnt_q + (IW+1)'(1);
          if (fail_cnt_q == '0) ffi_d = idx_q;
        end
        if (idx_q == IW'(NUM_VEC - 1)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = LAUNCH;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        pass_d  = (fail_cnt_q == '0);
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        core_en_d = 1'b0;
      end
    endcase
  end

  assign core_en        = core_en_q;
  assign core_data_in   = din_q;
  assign core_key_in    = key_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
module tb_aes_kat_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- instance A: 4 vectors, EN_HOLD=1, TIMEOUT_CYC=8 ----------------
  localparam int LAT_A = 2;
  logic         rst_a, start_a, wr_en_a;
  logic [1:0]   wr_idx_a;
  logic [127:0] wr_pt_a, wr_key_a, wr_ct_a;
  logic         en_a, vld_a, busy_a, done_a, pass_a;
  logic [127:0] din_a, kin_a, dout_a;
  logic [2:0]   fc_a;
  logic [1:0]   ffi_a;

  aes_kat_sequencer #(.NUM_VEC(4), .DATA_W(128), .TIMEOUT_CYC(8), .EN_HOLD(1)) dut_a (
    .AES_clk(clk), .AES_rst_n(rst_a),
    .vec_wr_en(wr_en_a), .vec_wr_idx(wr_idx_a),
    .vec_wr_pt(wr_pt_a), .vec_wr_key(wr_key_a), .vec_wr_ct(wr_ct_a),
    .start(start_a), .core_en(en_a), .core_data_in(din_a), .core_key_in(kin_a),
    .core_data_out(dout_a), .core_data_out_valid(vld_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_cnt(fc_a), .first_fail_idx(ffi_a));

  logic [127:0] pt_tab [4];
  logic [127:0] key_tab[4];
  logic [127:0] ct_tab [4];
  logic [3:0]   corrupt_a;
  logic         never_a;

  function automatic logic [127:0] model_a(input logic [127:0] d, input logic [127:0] k);
    for (int i = 0; i < 4; i++)
      if (d == pt_tab[i] && k == key_tab[i])
        return ct_tab[i] ^ (corrupt_a[i] ? 128'h1 : 128'h0);
    return d ^ k;
  endfunction

  logic en_prev_a;
  int   cd_a;
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      en_prev_a <= 1'b0; cd_a <= 0; vld_a <= 1'b0; dout_a <= '0;
    end else begin
      en_prev_a <= en_a;
      vld_a     <= 1'b0;
      if (en_a && !en_prev_a && !never_a) cd_a <= LAT_A;
      else if (cd_a > 0) begin
        cd_a <= cd_a - 1;
        if (cd_a == 1) begin
          vld_a  <= 1'b1;
          dout_a <= model_a(din_a, kin_a);
        end
      end
    end
  end

  int done_tot_a = 0, busy_tot_a = 0, en_tot_a = 0;
  always @(posedge clk) begin
    if (done_a) done_tot_a <= done_tot_a + 1;
    if (busy_a) busy_tot_a <= busy_tot_a + 1;
    if (en_a)   en_tot_a   <= en_tot_a + 1;
  end

  // ---------------- instance B: 1 vector, EN_HOLD=0 ----------------
  localparam logic [127:0] FPT  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] FKEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] FCT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam int LAT_B = 3;
  logic         rst_b, start_b, wr_en_b;
  logic [0:0]   wr_idx_b;
  logic [127:0] wr_pt_b, wr_key_b, wr_ct_b;
  logic         en_b, vld_b, busy_b, done_b, pass_b;
  logic [127:0] din_b, kin_b, dout_b;
  logic [1:0]   fc_b;
  logic [0:0]   ffi_b;
  logic         corrupt_b;

  aes_kat_sequencer #(.NUM_VEC(1), .DATA_W(128), .TIMEOUT_CYC(64), .EN_HOLD(0)) dut_b (
    .AES_clk(clk), .AES_rst_n(rst_b),
    .vec_wr_en(wr_en_b), .vec_wr_idx(wr_idx_b),
    .vec_wr_pt(wr_pt_b), .vec_wr_key(wr_key_b), .vec_wr_ct(wr_ct_b),
    .start(start_b), .core_en(en_b), .core_data_in(din_b), .core_key_in(kin_b),
    .core_data_out(dout_b), .core_data_out_valid(vld_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_cnt(fc_b), .first_fail_idx(ffi_b));

  logic en_prev_b;
  int   cd_b;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      en_prev_b <= 1'b0; cd_b <= 0; vld_b <= 1'b0; dout_b <= '0;
    end else begin
      en_prev_b <= en_b;
      vld_b     <= 1'b0;
      if (en_b && !en_prev_b) cd_b <= LAT_B;
      else if (cd_b > 0) begin
        cd_b <= cd_b - 1;
        if (cd_b == 1) begin
          vld_b  <= 1'b1;
          dout_b <= (din_b == FPT && kin_b == FKEY) ? (FCT ^ (corrupt_b ? 128'h1 : 128'h0))
                                                    : (din_b ^ kin_b);
        end
      end
    end
  end

  int done_tot_b = 0, en_tot_b = 0, opnd_bad_b = 0;
  always @(posedge clk) begin
    if (done_b) done_tot_b <= done_tot_b + 1;
    if (en_b)   en_tot_b   <= en_tot_b + 1;
    if (busy_b && din_b != '0 && (din_b != FPT || kin_b != FKEY))
      opnd_bad_b <= opnd_bad_b + 1;
  end

  // ---------------- helpers ----------------
  task automatic run_a(input bit poke, output int dn, output int bc, output int ec);
    int d0, b0, e0;
    d0 = done_tot_a; b0 = busy_tot_a; e0 = en_tot_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (poke && c == 4) begin
        start_a = 1'b1; wr_en_a = 1'b1; wr_idx_a = 2'd0;
        wr_pt_a = '1; wr_key_a = '1; wr_ct_a = '1;
      end else begin
        start_a = 1'b0; wr_en_a = 1'b0;
      end
    end
    dn = done_tot_a - d0; bc = busy_tot_a - b0; ec = en_tot_a - e0;
  endtask

  task automatic run_b(output int dn, output int ec);
    int d0, e0;
    d0 = done_tot_b; e0 = en_tot_b;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (100) @(negedge clk);
    dn = done_tot_b - d0; ec = en_tot_b - e0;
  endtask

  typedef struct {
    logic [3:0] mask;
    bit         nv;
    int         fc;
    int         ffi;
    bit         pass;
    int         busy_cyc;
    int         en_cyc;
  } row_t;

  row_t rows[6];

  initial begin
    int dn, bc, ec;
    rows[0] = '{4'b0000, 1'b0, 0, 0, 1'b1, 25, 16};
    rows[1] = '{4'b0100, 1'b0, 1, 2, 1'b0, 25, 16};
    rows[2] = '{4'b1010, 1'b0, 2, 1, 1'b0, 25, 16};
    rows[3] = '{4'b1110, 1'b0, 3, 1, 1'b0, 25, 16};
    rows[4] = '{4'b0000, 1'b1, 4, 0, 1'b0, 41, 32};
    rows[5] = '{4'b1001, 1'b0, 2, 0, 1'b0, 25, 16};
    for (int i = 0; i < 4; i++) begin
      pt_tab[i]  = {4{32'hA000_0000 + 32'(i)}};
      key_tab[i] = {4{32'h0B00_0000 + 32'(i * 17)}};
      ct_tab[i]  = {4{32'h00C0_0000 + 32'(i * 33 + 5)}};
    end

    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 0; wr_en_a = 0; wr_idx_a = 0; wr_pt_a = 0; wr_key_a = 0; wr_ct_a = 0;
    start_b = 0; wr_en_b = 0; wr_idx_b = 0; wr_pt_b = 0; wr_key_b = 0; wr_ct_b = 0;
    corrupt_a = 0; never_a = 0; corrupt_b = 0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_core_en", en_a, 0);
    chk("rst_fail_cnt", fc_a, 0);
    chk("rst_first_fail", ffi_a, 0);
    chk("rst_core_data_in", din_a, 0);
    chk("rst_core_key_in", kin_a, 0);
    rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en_a = 1'b1; wr_idx_a = 2'(i);
      wr_pt_a = pt_tab[i]; wr_key_a = key_tab[i]; wr_ct_a = ct_tab[i];
    end
    @(negedge clk); wr_en_a = 1'b0;

    for (int r = 0; r < 6; r++) begin
      corrupt_a = rows[r].mask; never_a = rows[r].nv;
      run_a(1'b0, dn, bc, ec);
      chk($sformatf("row%0d_done_pulses", r), 128'(dn), 1);
      chk($sformatf("row%0d_fail_cnt", r), fc_a, 128'(rows[r].fc));
      chk($sformatf("row%0d_first_fail_idx", r), ffi_a, 128'(rows[r].ffi));
      chk($sformatf("row%0d_pass", r), pass_a, rows[r].pass);
      chk($sformatf("row%0d_busy_cycles", r), 128'(bc), 128'(rows[r].busy_cyc));
      chk($sformatf("row%0d_core_en_cycles", r), 128'(ec), 128'(rows[r].en_cyc));
    end

    // start and a store write pulsed mid-run must both be ignored
    corrupt_a = 0; never_a = 0;
    run_a(1'b1, dn, bc, ec);
    chk("midrun_done_pulses", 128'(dn), 1);
    chk("midrun_pass", pass_a, 1);
    run_a(1'b0, dn, bc, ec);
    chk("after_midrun_pass", pass_a, 1);
    chk("after_midrun_fail_cnt", fc_a, 0);

    // asynchronous reset in the middle of WAIT
    begin
      int d0;
      d0 = done_tot_a;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (en_a) break;
        @(negedge clk);
      end
      chk("pre_reset_core_en", en_a, 1);
      #2 rst_a = 1'b0;
      #1;
      chk("async_rst_busy", busy_a, 0);
      chk("async_rst_core_en", en_a, 0);
      chk("async_rst_core_data_in", din_a, 0);
      chk("async_rst_core_key_in", kin_a, 0);
      chk("async_rst_done", done_a, 0);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      repeat (100) @(negedge clk);
      chk("reset_abort_no_done", 128'(done_tot_a - d0), 0);
      chk("reset_abort_busy", busy_a, 0);
    end

    // store is zero after reset: model maps zero operands to zero, so every vector passes
    corrupt_a = 4'b1111;
    run_a(1'b0, dn, bc, ec);
    chk("zero_store_done", 128'(dn), 1);
    chk("zero_store_fail_cnt", fc_a, 0);
    chk("zero_store_pass", pass_a, 1);

    // instance B: single FIPS-197 vector with a one-cycle core_en pulse
    @(negedge clk);
    wr_en_b = 1'b1; wr_idx_b = 1'b0; wr_pt_b = FPT; wr_key_b = FKEY; wr_ct_b = FCT;
    @(negedge clk); wr_en_b = 1'b0;
    run_b(dn, ec);
    chk("b_done_pulses", 128'(dn), 1);
    chk("b_pass", pass_b, 1);
    chk("b_fail_cnt", fc_b, 0);
    chk("b_core_en_cycles", 128'(ec), 1);
    chk("b_core_data_in_held", din_b, FPT);
    chk("b_core_key_in_held", kin_b, FKEY);
    corrupt_b = 1'b1;
    run_b(dn, ec);
    chk("b_bad_done_pulses", 128'(dn), 1);
    chk("b_bad_pass", pass_b, 0);
    chk("b_bad_fail_cnt", fc_b, 1);
    chk("b_bad_first_fail", ffi_b, 0);
    chk("b_bad_core_en_cycles", 128'(ec), 1);
    chk("b_operands_stable", 128'(opnd_bad_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
